key_click_decoder: RTL and testbench
====================================

Name: key_click_decoder

Overview:
- Sits directly downstream of the key debounce stage.
- Consumes that stage's single-cycle debounced-press pulse and classifies press bursts as single, double or triple clicks, based on the gap between presses.
- Emits one single-cycle pulse per classified burst for the mode/LED control logic that follows.
- One clock domain.

Parameters:
- WIN_MAX, 24'd14_999_999: inter-click window terminal count. The window is 300 ms at 50 MHz. The value must fit in 24 bits.

Ports:
- sys_clk  input  1  system clock; all logic is on the rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- key_flag  input  1  debounced press pulse from the upstream debounce stage; nominally high for one cycle per press.
- click_single  output  1  one-cycle pulse: burst of exactly one press completed.
- click_double  output  1  one-cycle pulse: burst of exactly two presses completed.
- click_triple  output  1  one-cycle pulse: third press of a burst received.
- busy  output  1  high while a burst is being collected (state != IDLE).

Behaviour:

Reset:
- Asynchronous on sys_rst_n low.
- State = IDLE, win_cnt = 0.
- click_single, click_double, click_triple and busy are all 0.

Registers:
- 2-bit state: IDLE, WAIT1, WAIT2.
- 24-bit win_cnt.
- All outputs are registered; busy is a registered decode of the next state.

Counter:
- win_cnt is cleared to 0 on every edge where key_flag = 1.
- Otherwise, in WAIT1/WAIT2 it increments by 1 per clock.
- In IDLE it holds at 0.
- It never passes WIN_MAX; the state leaves before that can happen.

Timeout:
- Timeout = (win_cnt == WIN_MAX) and key_flag = 0, evaluated in WAIT1/WAIT2.

Transitions (evaluated at each rising edge):
- IDLE: key_flag = 1 -> WAIT1.
- WAIT1: key_flag = 1 -> WAIT2. Timeout -> IDLE, and click_single = 1 for the following cycle.
- WAIT2: key_flag = 1 -> IDLE, and click_triple = 1 for the following cycle. Timeout -> IDLE, and click_double = 1 for the following cycle.
- Click outputs are 0 in every other cycle. At most one click output is high in any cycle.

Latency:
- Let E0 be the edge on which key_flag is sampled high. After edge Ek, win_cnt = k.
- click_single / click_double rise after edge E(WIN_MAX+1) counted from the last press. The pulse lasts exactly one cycle.
- click_triple rises after the edge that samples the third press.
- busy rises after the edge sampling the first press. It falls after the same edge on which the click pulse rises.

Boundary conditions:
- key_flag = 1 on the same edge that win_cnt == WIN_MAX: the press wins. It counts as a further click and the window restarts; no timeout pulse is produced.
- key_flag high for N consecutive cycles (upstream protocol violation): each high cycle counts as one press.
- A press in IDLE on the edge directly after a click pulse is emitted starts a new burst normally.
- No burst exceeds three presses. A fourth press after a triple starts a new burst from IDLE.
- Reset asserted mid-burst: the burst is discarded. No click pulse is emitted after reset release.
- win_cnt arithmetic is unsigned 24-bit. WIN_MAX = 0 is legal and gives timeout on the first cycle in WAIT1/WAIT2 without a press.

Test Plan (WIN_MAX = 9):
1. Assert sys_rst_n low mid-cycle with key_flag = 1 -> all outputs 0 immediately. After release with key_flag = 0 for 30 cycles -> no pulses; busy stays 0.
2. Single key_flag pulse at E0 -> busy = 1 from after E0. click_single = 1 for one cycle after E10, then busy = 0. click_double and click_triple never rise.
3. Pulses at E0 and E5 -> click_double = 1 for one cycle after E15. No click_single at any time.
4. Pulses at E0, E3, E6 -> click_triple = 1 for one cycle after E6, and busy = 0 in that same cycle. A further pulse at E7 -> busy = 1 again; click_single after E17.
5. Pulses at E0 and E9 (second press coincides with win_cnt = 9) -> no click_single. click_double after E19. A separate run with pulses at E0 and E11 -> click_single after E10, click_single after E21.
6. Pulses at E0 and E4, then sys_rst_n low for 3 cycles starting at E6, then no presses -> no click pulse ever. A fresh pulse after release -> click_single exactly 10 clocks later.

Source files
------------

// File: rtl/key_click_decoder.sv
// Click-burst classifier: turns debounced press pulses into single/double/triple
// click pulses, based on the spacing between presses.
module key_click_decoder #(
  parameter logic [23:0] WIN_MAX = 24'd14_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_flag,
  output logic click_single,
  output logic click_double,
  output logic click_triple,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [23:0] win_cnt_reg;
  logic [23:0] win_cnt_next;
  logic        timeout;
  logic        single_next;
  logic        double_next;
  logic        triple_next;
  logic        busy_next;

  // A press on the terminal-count edge suppresses the timeout: the press wins.
  assign timeout = (state_reg != IDLE) && (win_cnt_reg == WIN_MAX) && !key_flag;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= IDLE;
      win_cnt_reg  <= 24'd0;
      click_single <= 1'b0;
      click_double <= 1'b0;
      click_triple <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      win_cnt_reg  <= win_cnt_next;
      click_single <= single_next;
      click_double <= double_next;
      click_triple <= triple_next;
      busy         <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    win_cnt_next = win_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (key_flag) state_next = WAIT1;
      end
      WAIT1: begin
        if (key_flag)     state_next = WAIT2;
        else if (timeout) state_next = IDLE;
      end
      WAIT2: begin
        if (key_flag || timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Window restarts on every press; it parks at zero whenever no burst is open.
    if (key_flag)
      win_cnt_next = 24'd0;
    else if (state_reg == IDLE || timeout)
      win_cnt_next = 24'd0;
    else
      win_cnt_next = win_cnt_reg + 24'd1;
  end

  always_comb begin
    single_next = (state_reg == WAIT1) && timeout;
    double_next = (state_reg == WAIT2) && timeout;
    triple_next = (state_reg == WAIT2) && key_flag;
    busy_next   = (state_next != IDLE);
  end

endmodule

// File: tb/tb_key_click_decoder.sv
// Randomized and directed bench for key_click_decoder with a press-timing
// reference model feeding a scoreboard of expected click events.
module tb_key_click_decoder;

  localparam int WIN = 9;

  logic sys_clk;
  logic sys_rst_n;
  logic key_flag;
  logic click_single;
  logic click_double;
  logic click_triple;
  logic busy;

  key_click_decoder #(.WIN_MAX(24'd9)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_flag     (key_flag),
    .click_single (click_single),
    .click_double (click_double),
    .click_triple (click_triple),
    .busy         (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         cyc;
    logic [2:0] kind;   // {triple, double, single}
  } ev_t;

  ev_t  click_q[$];
  bit   busy_q[$];
  int   cyc;
  int   m_cnt;
  int   m_last;
  int   total;
  int   bad;
  bit   mon_en;
  bit   done;

  // Reference: a burst is a press count plus the time of its latest press.
  task automatic model(input bit k);
    logic [2:0] ev;
    ev = 3'b000;
    if (k) begin
      m_cnt++;
      m_last = cyc;
      if (m_cnt == 3) begin
        ev    = 3'b100;
        m_cnt = 0;
      end
    end else if (m_cnt > 0 && (cyc - m_last) == WIN + 1) begin
      ev    = (m_cnt == 1) ? 3'b001 : 3'b010;
      m_cnt = 0;
    end
    if (ev != 3'b000) click_q.push_back('{cyc, ev});
    busy_q.push_back(m_cnt > 0);
  endtask

  task automatic step(input bit k);
    @(negedge sys_clk);
    key_flag = k;
    @(posedge sys_clk);
    cyc++;
    model(k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic gap_press(input int gap);
    idle(gap - 1);
    step(1'b1);
  endtask

  task automatic check_zero(input string name, input logic v);
    total++;
    if (v !== 1'b0) begin
      bad++;
      $display("FAIL %s during reset: got %b want 0", name, v);
    end
  endtask

  // Reset asserted mid-cycle with key_flag high; outputs must clear at once.
  task automatic rst_burst(input int n);
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    key_flag  = 1'b1;
    mon_en    = 1'b0;
    #1;
    check_zero("click_single", click_single);
    check_zero("click_double", click_double);
    check_zero("click_triple", click_triple);
    check_zero("busy", busy);
    click_q.delete();
    busy_q.delete();
    m_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      cyc++;
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    key_flag  = 1'b0;
    mon_en    = 1'b1;
  endtask

  task automatic monitor();
    logic [2:0] got;
    bit         exp_b;
    while (!done) begin
      @(negedge sys_clk);
      if (mon_en) begin
        got = {click_triple, click_double, click_single};
        if (busy_q.size() > 0) begin
          exp_b = busy_q.pop_front();
          total++;
          if (busy !== exp_b) begin
            bad++;
            $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, exp_b);
          end
        end
        while (click_q.size() > 0 && click_q[0].cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL missed_click cyc=%0d: got none want kind=%b", click_q[0].cyc, click_q[0].kind);
          void'(click_q.pop_front());
        end
        if (got != 3'b000) begin
          total++;
          if (click_q.size() == 0 || click_q[0].cyc != cyc || click_q[0].kind != got) begin
            bad++;
            $display("FAIL click cyc=%0d: got kind=%b want %s", cyc, got,
                     (click_q.size() > 0 && click_q[0].cyc == cyc) ? "other kind" : "no pulse");
            if (click_q.size() > 0 && click_q[0].cyc == cyc) void'(click_q.pop_front());
          end else begin
            $display("click cyc=%0d kind=%b ok", cyc, got);
            void'(click_q.pop_front());
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    int r;
    int gap;
    sys_rst_n = 1'b0;
    key_flag  = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mon_en    = 1'b1;
    idle(2);

    // 1: mid-cycle reset with key_flag high, then quiet
    rst_burst(2);
    idle(30);
    // 2: single
    step(1'b1); idle(14);
    // 3: double at gap 5
    step(1'b1); gap_press(5); idle(14);
    // 4: triple, then immediate new burst
    step(1'b1); gap_press(3); gap_press(3); gap_press(1); idle(14);
    // 5: second press near the window edge, and just past it
    step(1'b1); gap_press(9); idle(14);
    step(1'b1); gap_press(11); idle(14);
    step(1'b1); gap_press(10); idle(14);
    // 6: reset mid-burst discards it
    step(1'b1); gap_press(4); step(1'b0);
    rst_burst(3);
    idle(15);
    step(1'b1); idle(14);
    // back-to-back high cycles count as separate presses
    step(1'b1); step(1'b1); step(1'b1); step(1'b1); idle(14);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      gap = 1;
      else if (r <= 3) gap = $urandom_range(WIN - 1, WIN + 3);
      else             gap = $urandom_range(2, 25);
      gap_press(gap);
      if ($urandom_range(0, 59) == 0) begin
        rst_burst($urandom_range(1, 4));
        idle($urandom_range(0, 3));
      end
    end
    idle(20);
    done = 1'b1;
  endtask

  initial begin
    cyc    = 0;
    m_cnt  = 0;
    m_last = 0;
    total  = 0;
    bad    = 0;
    mon_en = 1'b0;
    done   = 1'b0;
    fork
      stimulus();
      monitor();
    join
    while (click_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL missed_click cyc=%0d: got none want kind=%b", click_q[0].cyc, click_q[0].kind);
      void'(click_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
